joy_db15_scan: RTL
==================

# joy_db15_scan

Parametrised serial reader for DB15 joystick splitters. It generates the shift clock and parallel-load strobe for one splitter, or several daisy-chained ones, and deserialises the bit stream into per-player active-high button words. It can require two identical frames before publishing. It sits between the board's DB15 splitter pins and the core's joystick inputs, as the drop-in generalisation of the fixed two-player 24-bit reader.

## Interface
Parameters:
- CLK_DIV_W, 8: divider width; one bit slot lasts 2^CLK_DIV_W clk cycles; JOY_CLK is the divider MSB.
- NUM_PAIRS, 1: number of chained two-player splitters (1..4); NUM_JOYS = 2*NUM_PAIRS.
- GAP_SLOTS, 8: idle slots after the data bits before the next load (0..255).

Ports:
- clk  in  1  system clock, 48-50 MHz nominal.
- reset  in  1  synchronous, active-high.
- JOY_CLK  out  1  splitter shift clock.
- JOY_LOAD  out  1  splitter load, active-low; low for all of slot 0.
- JOY_DATA  in  1  serial data, active-low buttons.
- joystick  out  16*NUM_JOYS  player p occupies [16p+15:16p]; bit layout is listed under Operation; active-high.
- frame_done  out  1  one-cycle pulse per completed frame.
- data_valid  out  1  high once the first frame has been published; sticky until reset.

## Operation
- FRAME_BITS = 24*NUM_PAIRS. SLOTS = FRAME_BITS + GAP_SLOTS. The slot counter is wide enough for SLOTS-1.
- tick: asserted when the divider equals 0.
- On each tick:
  - If slot < FRAME_BITS, sample JOY_DATA into the shadow frame at the position for that slot.
  - slot then increments, wrapping from SLOTS-1 to 0.
- Slot map within pair q, bit offset 24q, players 2q (P1) and 2q+1 (P2). For slots 0..23 the destinations are: P1 D,C,B,A,R,L,Dn,Up; P2 R,L,Dn,Up; P1 F,E,Sel,Start; P2 F,E,Sel,Start; P2 D,C,B,A.
- Player word bits: 0 R, 1 L, 2 Dn, 3 Up, 4 A, 5 B, 6 C, 7 D, 8 E, 9 F, 10 Start, 11 Select; 15:12 always 0.
- States:
  - LOAD: slot 0.
  - SHIFT: slots 1..FRAME_BITS-1.
  - GAP: remaining slots. When GAP_SLOTS=0, SHIFT wraps directly to LOAD.
- Frame end is the tick that samples slot FRAME_BITS-1. One clk later:
  - The shadow frame is inverted and copied to joystick.
  - frame_done pulses.
  - data_valid is set.
  - With JOY_DEBOUNCE_EN, the publish step changes as described under Configuration.
- Shadow frame bits reset to 1 (all released).

## Timing
- Reset values: divider 0, slot 0, joystick all 0, frame_done 0, data_valid 0, JOY_CLK 0, JOY_LOAD 0 (slot 0), shadow frame all 1.
- JOY_CLK period is 2^CLK_DIV_W clk cycles, 50% duty. Its falling edge coincides with tick.
- JOY_LOAD falls on the clk after the tick that wraps slot to 0. It rises on the clk after the tick that samples slot 0.
- Publish latency is 1 clk after the last-bit tick. joystick is stable between publishes.
- Frame period is SLOTS * 2^CLK_DIV_W clk cycles.
- Reset asserted mid-frame: the partial frame is discarded, outputs return to reset values, and scanning restarts at slot 0 on the first cycle after release.

## Configuration
- JOY_DEBOUNCE_EN defined:
  - Each completed frame is compared with the previous completed frame, kept in a second register.
  - joystick and data_valid update only when the two frames are equal.
  - frame_done still pulses every frame.
  - The first publish occurs at the end of the second frame at the earliest.
- JOY_DEBOUNCE_EN undefined: every frame is published unconditionally. The comparison register is not built.

## Structure
- Package joy_db15_pkg holds:
  - the 24-entry slot map constant (player-in-pair 0/1, word bit index);
  - button bit index localparams;
  - a function computing slot counter width from SLOTS.
- Sub-module joy_db15_tick: CLK_DIV_W divider producing tick and JOY_CLK, cleared by reset.

## Test plan
- CLK_DIV_W=2, NUM_PAIRS=1, JOY_DATA held 1 → JOY_LOAD low for clk 0..4; frame_done at clk 97, then every 128 clk; joystick=0; data_valid=1 from clk 97.
- JOY_DATA=0 only during slots 4 and 23 (P1 R, P2 A) → joystick[15:0]=16'h0001, joystick[31:16]=16'h0010.
- NUM_PAIRS=2, JOY_DATA=0 only in slot 24+15 (P3 Start) → joystick[47:32]=16'h0400, all other words 0, frame period (48+8)*4 clk.
- Reset pulsed at slot 10 with JOY_DATA=0 → all outputs 0 and JOY_LOAD low next clk; first frame_done 97 clk after release.
- JOY_DEBOUNCE_EN, P1 Up pressed in frame 1 only, then released in frames 2 and 3 → no publish at end of frame 1 or frame 2 (frames differ); publish of 0 at end of frame 3; data_valid first rises at frame 3.
- GAP_SLOTS=0 → JOY_LOAD low again immediately after slot 23; period 24*4 clk.

Source files
------------

// File: rtl/joy_db15_pkg.sv
// Shared types and constants for the DB15 joystick splitter reader.
// Slot map, button bit indices and slot counter sizing.
package joy_db15_pkg;

    localparam int PAIR_BITS = 24;

    localparam logic [3:0] BTN_R     = 4'd0;
    localparam logic [3:0] BTN_L     = 4'd1;
    localparam logic [3:0] BTN_DN    = 4'd2;
    localparam logic [3:0] BTN_UP    = 4'd3;
    localparam logic [3:0] BTN_A     = 4'd4;
    localparam logic [3:0] BTN_B     = 4'd5;
    localparam logic [3:0] BTN_C     = 4'd6;
    localparam logic [3:0] BTN_D     = 4'd7;
    localparam logic [3:0] BTN_E     = 4'd8;
    localparam logic [3:0] BTN_F     = 4'd9;
    localparam logic [3:0] BTN_START = 4'd10;
    localparam logic [3:0] BTN_SEL   = 4'd11;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } scan_st_e;

    typedef struct packed {
        logic       p2;
        logic [3:0] bit_idx;
    } slot_dst_t;

    // Destination of each serial slot within one two-player splitter.
    localparam slot_dst_t SLOT_MAP [PAIR_BITS] = '{
        '{1'b0, BTN_D},  '{1'b0, BTN_C},   '{1'b0, BTN_B},     '{1'b0, BTN_A},
        '{1'b0, BTN_R},  '{1'b0, BTN_L},   '{1'b0, BTN_DN},    '{1'b0, BTN_UP},
        '{1'b1, BTN_R},  '{1'b1, BTN_L},   '{1'b1, BTN_DN},    '{1'b1, BTN_UP},
        '{1'b0, BTN_F},  '{1'b0, BTN_E},   '{1'b0, BTN_SEL},   '{1'b0, BTN_START},
        '{1'b1, BTN_F},  '{1'b1, BTN_E},   '{1'b1, BTN_SEL},   '{1'b1, BTN_START},
        '{1'b1, BTN_D},  '{1'b1, BTN_C},   '{1'b1, BTN_B},     '{1'b1, BTN_A}
    };

    function automatic int slot_cnt_w(input int slots);
        return (slots <= 2) ? 1 : $clog2(slots);
    endfunction

endpackage

// File: rtl/joy_db15_tick.sv
// Bit-slot divider: tick marks the start of each slot, JOY_CLK is the MSB.
// The first tick after reset comes one full slot later.
module joy_db15_tick
    import joy_db15_pkg::*;
#(
    parameter int CLK_DIV_W = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o,
    output logic joy_clk_o
);

    logic [CLK_DIV_W-1:0] div_q, div_d;
    logic                 tick_q, tick_d;

    always_comb begin
        div_d  = div_q + 1'b1;
        tick_d = &div_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o    = tick_q;
    assign joy_clk_o = div_q[CLK_DIV_W-1];

endmodule

// File: rtl/joy_db15_scan.sv
// DB15 splitter chain reader; define JOY_DEBOUNCE_EN to publish only
// after two identical consecutive frames.
module joy_db15_scan
    import joy_db15_pkg::*;
#(
    parameter int CLK_DIV_W = 8,
    parameter int NUM_PAIRS = 1,
    parameter int GAP_SLOTS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    JOY_CLK,
    output logic                    JOY_LOAD,
    input  logic                    JOY_DATA,
    output logic [32*NUM_PAIRS-1:0] joystick,
    output logic                    frame_done,
    output logic                    data_valid
);

    localparam int NUM_JOYS   = 2 * NUM_PAIRS;
    localparam int FRAME_BITS = PAIR_BITS * NUM_PAIRS;
    localparam int SLOTS      = FRAME_BITS + GAP_SLOTS;
    localparam int SLOT_W     = slot_cnt_w(SLOTS);
    localparam int JOY_W      = 16 * NUM_JOYS;

    localparam logic [SLOT_W-1:0] LAST_BIT  = SLOT_W'(FRAME_BITS - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    logic                  tick;
    logic                  frame_end;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    scan_st_e              state_q, state_d;
    logic [FRAME_BITS-1:0] shadow_q, shadow_d;
    logic [JOY_W-1:0]      joy_q, joy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    wire  [JOY_W-1:0]      frame_w;

    joy_db15_tick #(
        .CLK_DIV_W(CLK_DIV_W)
    ) u_tick (
        .clk_i    (clk),
        .rst_i    (reset),
        .tick_o   (tick),
        .joy_clk_o(JOY_CLK)
    );

    always_comb begin
        slot_d   = slot_q;
        shadow_d = shadow_q;
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (tick && slot_q == SLOT_W'(i)) shadow_d[i] = JOY_DATA;
        end
        if (tick) slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        frame_end = tick && (slot_q == LAST_BIT);
    end

    // Shadow holds raw active-low bits in slot order; remap per player.
    for (genvar q = 0; q < NUM_PAIRS; q++) begin : g_pair
        for (genvar s = 0; s < PAIR_BITS; s++) begin : g_slot
            localparam int P = int'(SLOT_MAP[s].p2);
            localparam int B = int'(SLOT_MAP[s].bit_idx);
            assign frame_w[32*q + 16*P + B] = ~shadow_d[PAIR_BITS*q + s];
        end
    end

    for (genvar p = 0; p < NUM_JOYS; p++) begin : g_pad
        assign frame_w[16*p+12 +: 4] = 4'b0;
    end

`ifdef JOY_DEBOUNCE_EN
    logic [FRAME_BITS-1:0] prev_q, prev_d;
    logic                  prev_vld_q, prev_vld_d;

    always_comb begin
        joy_d      = joy_q;
        valid_d    = valid_q;
        done_d     = frame_end;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        if (frame_end) begin
            prev_d     = shadow_d;
            prev_vld_d = 1'b1;
            if (prev_vld_q && prev_q == shadow_d) begin
                joy_d   = frame_w;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '1;
            prev_vld_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
        end
    end
`else
    always_comb begin
        joy_d   = joy_q;
        valid_d = valid_q;
        done_d  = frame_end;
        if (frame_end) begin
            joy_d   = frame_w;
            valid_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q   <= '0;
            shadow_q <= '1;
            joy_q    <= '0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            joy_q    <= joy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_LOAD;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                ST_LOAD:  state_d = ST_SHIFT;
                ST_SHIFT: if (slot_q == LAST_BIT)
                              state_d = (GAP_SLOTS == 0) ? ST_LOAD : ST_GAP;
                ST_GAP:   if (slot_q == LAST_SLOT) state_d = ST_LOAD;
                default:  state_d = ST_LOAD;
            endcase
        end
    end

    always_comb begin
        JOY_LOAD = (state_q != ST_LOAD);
    end

    assign joystick   = joy_q;
    assign frame_done = done_q;
    assign data_valid = valid_q;

endmodule
